// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - op code constants OP_ADD .. OP_MFLO (0x16-0x1F are illegal)
//   - FSM state type alu_state_t
//   - is_muldiv(): true for the op codes served by the iterative unit
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_SLT   = 5'h02;
    localparam logic [4:0] OP_SRA   = 5'h03;
    localparam logic [4:0] OP_SLL   = 5'h04;
    localparam logic [4:0] OP_SLLI  = 5'h05;
    localparam logic [4:0] OP_GTU   = 5'h06;
    localparam logic [4:0] OP_LTU   = 5'h07;
    localparam logic [4:0] OP_EQ    = 5'h08;
    localparam logic [4:0] OP_AND   = 5'h09;
    localparam logic [4:0] OP_OR    = 5'h0A;
    localparam logic [4:0] OP_SRAI  = 5'h0B;
    localparam logic [4:0] OP_NOR   = 5'h0C;
    localparam logic [4:0] OP_XOR   = 5'h0D;
    localparam logic [4:0] OP_SRL   = 5'h0E;
    localparam logic [4:0] OP_SRLI  = 5'h0F;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MFHI  = 5'h14;
    localparam logic [4:0] OP_MFLO  = 5'h15;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } alu_state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring divide, one bit per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset (aborts any operation)
//   start           load operands and begin (WIDTH busy cycles follow)
//   is_signed       treat a/b as two's complement
//   is_div          1: divide (lo=quotient, hi=remainder), 0: multiply ({hi,lo})
//   a, b            operands, sampled only on start
//   done            high during the last busy cycle; hi/lo valid then
//   hi, lo          final, sign-corrected result (combinational, valid with done)
// Divide-by-zero and signed MIN/-1 are resolved by the caller and never started.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic             div_mode;
    logic             neg_q;
    logic             neg_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] dvs;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    // -MIN wraps back to MIN, which is the correct unsigned magnitude.
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] prod;

    // Multiply: acc_hi holds the running upper half, acc_lo shifts the
    // multiplier out as product bits shift in.
    // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend
    // out as quotient bits shift in.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, dvs};
        nxt_hi   = mul_sum[WIDTH:1];
        nxt_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (div_mode) begin
            if (!div_diff[WIDTH]) begin
                nxt_hi = div_diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_sh[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod = {nxt_hi, nxt_lo};
        if (div_mode) begin
            lo = neg_q ? -nxt_lo : nxt_lo;
            hi = neg_r ? -nxt_hi : nxt_hi;
        end else begin
            {hi, lo} = neg_q ? -prod : prod;
        end
    end

    assign done = busy & (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            dvs      <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            cnt      <= CW'(WIDTH - 1);
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            dvs      <= b_mag;
        end else if (busy) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Execute-stage ALU with registered result, valid/ready handshake and
// HI/LO registers fed by an iterative multiply/divide unit.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake (accept = both high at clk edge)
//   op, x, y, shamt      op code, operands rs/rt, immediate shift amount
//   out_valid/out_ready  result handshake
//   res                  result
//   v, c_out             signed overflow / adder carry (ADD, SUB only)
//   zero                 res == 0
//
// state | meaning
// IDLE  | no result held, ready for an op
// MUL   | iterative multiply in progress
// DIV   | iterative divide in progress
// DONE  | result held on res, out_valid high
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             v,
    output logic             c_out,
    output logic             zero
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_t       state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic accept;
    logic op_div;
    logic op_signed;
    logic div_zero;
    logic div_ovf;
    logic div_special;
    logic md_start;
    logic md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign in_ready    = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid & in_ready;
    assign op_div      = (op == OP_DIV) | (op == OP_DIVU);
    assign op_signed   = (op == OP_MULT) | (op == OP_DIV);
    assign div_zero    = (y == '0);
    assign div_ovf     = (op == OP_DIV) & (x == MIN) & (y == '1);
    assign div_special = op_div & (div_zero | div_ovf);
    assign md_start    = accept & is_muldiv(op) & ~div_special;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_signed (op_signed),
        .is_div    (op_div),
        .a         (x),
        .b         (y),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    logic [WIDTH-1:0] y_add;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_v;
    logic             sc_c;

    // SUB reuses the adder as x + ~y + 1; v compares operand signs into the MSB.
    always_comb begin
        y_add   = (op == OP_SUB) ? ~y : y;
        add_sum = {1'b0, x} + {1'b0, y_add} + (WIDTH+1)'(op == OP_SUB);
        sc_res  = '0;
        sc_v    = 1'b0;
        sc_c    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = (x[WIDTH-1] == y_add[WIDTH-1]) & (add_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SLT:  sc_res = WIDTH'($signed(x) < $signed(y));
            OP_GTU:  sc_res = WIDTH'(x > y);
            OP_LTU:  sc_res = WIDTH'(x < y);
            OP_EQ:   sc_res = WIDTH'(x == y);
            OP_SRA:  sc_res = WIDTH'($signed(x) >>> y[SHW-1:0]);
            OP_SRAI: sc_res = WIDTH'($signed(x) >>> shamt);
            OP_SLL:  sc_res = x << y[SHW-1:0];
            OP_SLLI: sc_res = x << shamt;
            OP_SRL:  sc_res = x >> y[SHW-1:0];
            OP_SRLI: sc_res = x >> shamt;
            OP_AND:  sc_res = x & y;
            OP_OR:   sc_res = x | y;
            OP_NOR:  sc_res = ~(x | y);
            OP_XOR:  sc_res = x ^ y;
            OP_MFHI: sc_res = hi_q;
            OP_MFLO: sc_res = lo_q;
            default: sc_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            res   <= '0;
            v     <= 1'b0;
            c_out <= 1'b0;
            zero  <= 1'b1;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                MUL, DIV: begin
                    if (md_done) begin
                        hi_q  <= md_hi;
                        lo_q  <= md_lo;
                        res   <= md_lo;
                        zero  <= (md_lo == '0);
                        v     <= 1'b0;
                        c_out <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_muldiv(op)) begin
                            v     <= 1'b0;
                            c_out <= 1'b0;
                            if (div_special) begin
                                // Resolved without iterating: both cases give a nonzero LO.
                                hi_q  <= div_zero ? x : '0;
                                lo_q  <= div_zero ? '1 : MIN;
                                res   <= div_zero ? '1 : MIN;
                                zero  <= 1'b0;
                                state <= DONE;
                            end else begin
                                state <= op_div ? DIV : MUL;
                            end
                        end else begin
                            res   <= sc_res;
                            v     <= sc_v;
                            c_out <= sc_c;
                            zero  <= (sc_res == '0);
                            state <= DONE;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, v, c_out, zero;
    logic [4:0]  op, shamt;
    logic [31:0] x, y, res;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_v, h_c, h_zero;
    logic [4:0]  h_op;
    logic [3:0]  h_shamt;
    logic [15:0] h_x, h_y, h_res;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .x(x), .y(y), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .v(v), .c_out(c_out), .zero(zero)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
        .x(h_x), .y(h_y), .shamt(h_shamt), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .res(h_res), .v(h_v), .c_out(h_c), .zero(h_zero)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] r;
        logic        vv;
        logic        cc;
        int          acc;
        int          exp;
        bit          seen;
    } exp_t;
    exp_t q[$];

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference behaviour from plain integer arithmetic; updates model HI/LO.
    task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sa, output logic [31:0] r, output logic vv,
                         output logic cc, output int lat);
        longint          sr;
        longint          p;
        longint unsigned ur;
        int              qq, rr;
        r = '0; vv = 1'b0; cc = 1'b0; lat = 1;
        case (o)
            OP_ADD: begin
                ur = {32'b0, a} + {32'b0, b};
                r  = ur[31:0];
                cc = ur[32];
                sr = longint'($signed(a)) + longint'($signed(b));
                vv = (sr != longint'($signed(r)));
            end
            OP_SUB: begin
                r  = a - b;
                cc = (a >= b);
                sr = longint'($signed(a)) - longint'($signed(b));
                vv = (sr != longint'($signed(r)));
            end
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_GTU:  r = (a > b) ? 32'd1 : 32'd0;
            OP_LTU:  r = (a < b) ? 32'd1 : 32'd0;
            OP_EQ:   r = (a == b) ? 32'd1 : 32'd0;
            OP_SRA:  r = 32'($signed(a) >>> b[4:0]);
            OP_SRAI: r = 32'($signed(a) >>> sa);
            OP_SLL:  r = a << b[4:0];
            OP_SLLI: r = a << sa;
            OP_SRL:  r = a >> b[4:0];
            OP_SRLI: r = a >> sa;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 33;
            end
            OP_MULTU: begin
                ur = {32'b0, a} * {32'b0, b};
                m_hi = ur[63:32]; m_lo = ur[31:0]; r = m_lo; lat = 33;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = 32'h0;
                end else if (o == OP_DIV) begin
                    qq = $signed(a) / $signed(b);
                    rr = $signed(a) % $signed(b);
                    m_lo = qq; m_hi = rr; lat = 33;
                end else begin
                    m_lo = a / b; m_hi = a % b; lat = 33;
                end
                r = m_lo;
            end
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            default: r = '0;
        endcase
    endtask

    // Pins the model against hand-computed values without disturbing its HI/LO.
    task automatic pin(input string nm, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ev, input logic ec,
                       input logic [31:0] ehi, input int elat);
        logic [31:0] sh, sl, r;
        logic vv, cc;
        int lat;
        sh = m_hi; sl = m_lo;
        model(o, a, b, 5'd0, r, vv, cc, lat);
        chk({nm, "_res"}, r, er);
        chk({nm, "_v"}, vv, ev);
        chk({nm, "_c"}, cc, ec);
        chk({nm, "_hi"}, m_hi, ehi);
        chk({nm, "_lat"}, lat, elat);
        m_hi = sh; m_lo = sl;
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
        exp_t e;
        int n;
        logic [31:0] r;
        logic vv, cc;
        int lat;
        op = o; x = a; y = b; shamt = sa; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", {63'b0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        model(o, a, b, sa, r, vv, cc, lat);
        e.r = r; e.vv = vv; e.cc = cc; e.acc = cyc; e.exp = cyc + lat; e.seen = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = $urandom; y = $urandom; shamt = 5'($urandom);
    endtask

    // Single compare process for the 32-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    chk("res", res, q[0].r);
                    chk("v", v, q[0].vv);
                    chk("c_out", c_out, q[0].cc);
                    chk("zero", zero, q[0].r == 0);
                    if (!q[0].seen) begin
                        chk("latency", cyc, q[0].exp);
                        q[0].seen = 1'b1;
                    end
                    if (!out_ready) chk("in_ready_hold", in_ready, 0);
                    else void'(q.pop_front());
                end
            end else if (q.size() > 0) begin
                if (q[0].seen) begin
                    chk("result_dropped", {63'b0, out_valid}, 64'd1);
                    void'(q.pop_front());
                end else if (cyc > q[0].exp) begin
                    chk("late_result", cyc, q[0].exp);
                    void'(q.pop_front());
                end else if (cyc > q[0].acc) begin
                    chk("in_ready_busy", in_ready, 0);
                end
            end
        end
    end

    task automatic run16(input string nm, input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input int el);
        int n;
        h_op = o; h_x = a; h_y = b; h_shamt = '0; h_in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_ready"}, h_in_ready, 1);
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        h_x = 16'($urandom); h_y = 16'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!h_out_valid && n < 100);
        chk({nm, "_lat"}, n, el);
        chk({nm, "_res"}, h_res, er);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; in_valid = 1'b0; op = '0; x = '0; y = '0; shamt = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_op = '0; h_x = '0; h_y = '0; h_shamt = '0; h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_zero", zero, 1);
        chk("rst_v", v, 0);
        chk("rst_c", c_out, 0);
        chk("rst_in_ready", in_ready, 1);

        pin("m_add",  OP_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1);
        pin("m_sub",  OP_SUB,  32'd5, 32'd5, 32'h0, 1'b0, 1'b1, 32'h0, 1);
        pin("m_mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1'b0, 32'hFFFF_FFFF, 33);
        pin("m_div",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'hFFFF_FFFF, 33);
        pin("m_divz", OP_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd7, 1);
        pin("m_dovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1);

        issue(OP_ADD,  32'h7FFF_FFFF, 32'd1, 0);
        issue(OP_SUB,  32'd5, 32'd5, 0);
        issue(OP_ADD,  32'hFFFF_FFFF, 32'd1, 0);
        issue(OP_SUB,  32'd3, 32'd5, 0);
        issue(OP_SUB,  32'h8000_0000, 32'd1, 0);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'd1, 0);
        issue(OP_GTU,  32'hFFFF_FFFF, 32'd1, 0);
        issue(OP_LTU,  32'hFFFF_FFFF, 32'd1, 0);
        issue(OP_EQ,   32'h1234_5678, 32'h1234_5678, 0);
        issue(OP_SRA,  32'h8000_0000, 32'h0000_0024, 0);
        issue(OP_SLL,  32'h0000_00F1, 32'hFFFF_FFE8, 0);
        issue(OP_SLLI, 32'h0000_0003, 32'h0, 5'd30);
        issue(OP_SRAI, 32'h8765_4321, 32'h0, 5'd8);
        issue(OP_SRL,  32'h8765_4321, 32'h0000_0044, 0);
        issue(OP_SRLI, 32'h8765_4321, 32'h0, 5'd31);
        issue(OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        issue(OP_OR,   32'hF000_0000, 32'h0000_000F, 0);
        issue(OP_NOR,  32'hFFFF_0000, 32'h0000_FFFF, 0);
        issue(OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 0);
        issue(5'h17,   32'h1234_5678, 32'h1, 0);
        issue(5'h1F,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_MFLO,  32'h0, 32'h0, 0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_DIV,   32'd7, 32'hFFFF_FFFE, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_DIVU,  32'd7, 32'd0, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_DIV,   32'hFFFF_FFFB, 32'd0, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);
        issue(OP_DIVU,  32'hFFFF_FFF0, 32'd7, 0);
        issue(OP_MFHI,  32'h0, 32'h0, 0);

        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        issue(OP_SLLI, 32'd1, 32'h0, 5'd31);
        fork
            issue(OP_OR, 32'h0000_0F00, 32'h0000_00F0, 0);
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 8; i++) begin
            issue((i % 2) ? OP_OR : OP_AND, $urandom, $urandom, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        issue(OP_MULTU, 32'd12345, 32'd678, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        m_hi = '0; m_lo = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_res", res, 0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abort_no_valid", cnt, 0);
        @(posedge clk);
        #1;
        issue(OP_MFLO, 32'h0, 32'h0, 0);
        issue(OP_MFHI, 32'h0, 32'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);

        run16("sra16",  OP_SRA,  16'h8000, 16'h0013, 16'hF000, 1);
        run16("divu16", OP_DIVU, 16'hFFFF, 16'h0003, 16'h5555, 17);
        run16("mfhi16", OP_MFHI, 16'h0000, 16'h0000, 16'h0000, 1);
        run16("mult16", OP_MULT, 16'hFFFD, 16'h0007, 16'hFFEB, 17);
        run16("mfhi16b", OP_MFHI, 16'h0000, 16'h0000, 16'hFFFF, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, pipelined successor to the execute-stage ALU. It supports WIDTH-bit operands, a registered result with a valid/ready handshake, and iterative signed/unsigned multiply and divide into HI/LO registers, as the MIPS MULT/DIV/MFHI/MFLO instructions require. It sits in the execute stage between the operand muxes and the EX/MEM register. The decode stage stalls while `in_ready` is low.

## Interface
- `WIDTH`, 32: operand and result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width. Localparam, not overridable.

Ports:
- `clk`  in  1: the block's one clock.
- `rst`  in  1: reset; synchronous, active-high.
- `in_valid`  in  1: an operation is presented.
- `in_ready`  out  1: the block accepts an operation this cycle.
- `op`  in  5: operation code (see Operation).
- `x`, `y`  in  WIDTH: operands (rs, rt).
- `shamt`  in  SHW: immediate shift amount.
- `out_valid`  out  1: the result fields are valid.
- `out_ready`  in  1: the consumer takes the result.
- `res`  out  WIDTH: result.
- `v`, `c_out`  out  1: signed overflow and carry out (ADD/SUB only, 0 otherwise).
- `zero`  out  1: `res` == 0.

## Operation
Op codes 0x00–0x0F are single-cycle:
- 0x00 ADD, 0x01 SUB (x + ~y + 1).
- 0x02 SLT signed, 0x06 GT unsigned, 0x07 LT unsigned, 0x08 EQ. Each returns 1 or 0, zero-extended.
- 0x03 SRA by y[SHW-1:0], 0x04 SLL by y[SHW-1:0], 0x05 SLL by shamt, 0x0B SRA by shamt, 0x0E SRL by y[SHW-1:0], 0x0F SRL by shamt. Upper bits of y are ignored.
- 0x09 AND, 0x0A OR, 0x0C NOR, 0x0D XOR.

Multi-cycle and HI/LO op codes:
- 0x10 MULT (signed), 0x11 MULTU: the 2·WIDTH product goes to {HI,LO}; `res` = LO.
- 0x12 DIV (signed), 0x13 DIVU: LO = quotient, HI = remainder; `res` = LO. Signed division truncates toward zero, and the remainder takes the sign of x.
- Divide by zero: LO = all-ones, HI = x.
- Signed MIN / −1: LO = MIN, HI = 0.
- 0x14 MFHI, 0x15 MFLO: single-cycle read of HI or LO.
- 0x16–0x1F are illegal: single-cycle, `res` = 0, flags 0, no HI/LO change.

ADD `v` = carry into MSB XOR carry out of MSB. SUB `c_out` is the raw adder carry (1 means no borrow).

State machine (`IDLE`, `MUL`, `DIV`, `DONE`):
- `IDLE`: on accept of a single-cycle op → `DONE` with the result computed. On accept of MULT/MULTU → `MUL`. On accept of DIV/DIVU → `DIV`. Operands are latched at accept, and signed operands are converted to magnitudes.
- `MUL`: shift-add, one bit per cycle, WIDTH cycles; sign fix-up on the last cycle; write HI/LO → `DONE`.
- `DIV`: restoring division, one bit per cycle, WIDTH cycles; sign fix-up on the last cycle; write HI/LO → `DONE`. Divide-by-zero and MIN/−1 are detected at accept and go straight to `DONE` with HI/LO written.
- `DONE`: `out_valid` = 1. On `out_ready`, go to `IDLE`. If a new op is also accepted in the same cycle, follow the `IDLE` transitions instead.

## Timing
- `in_ready` = (state == `IDLE`) | (state == `DONE` & `out_ready`). It is combinational from state and `out_ready`.
- Accept happens when `in_valid` & `in_ready` at a rising edge.
- Single-cycle op: `out_valid` rises on the edge after accept, giving latency 1. Back-to-back throughput is 1 op per cycle while `out_ready` = 1.
- MULT/DIV: `out_valid` rises WIDTH+1 edges after accept. HI/LO update on the same edge.
- Special-case divide: latency 1.
- MFHI/MFLO accepted on the same edge that a multiply/divide completes see the new HI/LO. This cannot happen while the unit is busy, because `in_ready` = 0.
- Output hold: while `out_valid` & !`out_ready`, `res`/`v`/`c_out`/`zero` stay stable and `in_ready` = 0.
- `op`/`x`/`y`/`shamt` are sampled only at accept. Changes during `MUL`/`DIV` have no effect.
- Reset: state `IDLE`; `out_valid`, `res`, `v`, `c_out`, HI, LO all 0; `zero` = 1; `in_ready` = 1 in the cycle after reset deasserts.
- Reset asserted mid-`MUL`/`DIV`: the operation is aborted, HI/LO are cleared, and no `out_valid` is produced.

## Structure
- Package `alu_pkg` holds:
  - op code constants `OP_ADD` … `OP_MFLO`;
  - state enum `alu_state_t`;
  - function `is_muldiv(op)`.
- Sub-module `alu_muldiv_iter` (param WIDTH): start pulse, signed flag, op select, operands in; `done`, `hi`, `lo` out. It holds the iteration counter, partial remainder/product and sign fix-up.
- The single-cycle datapath, handshake, HI/LO registers and FSM stay in `seq_alu`.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 1 → `res` 0x80000000, `v` 1, `c_out` 0, `out_valid` one cycle later. SUB 5 − 5 → `res` 0, `zero` 1, `c_out` 1.
- MULT −3 × 7 → LO 0xFFFFFFEB, HI 0xFFFFFFFF, `out_valid` exactly 33 cycles after accept, `in_ready` 0 throughout. MFHI next → 0xFFFFFFFF.
- DIV −7 / 2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. DIVU 7 / 0 → LO 0xFFFFFFFF, HI 7, latency 1. DIV 0x80000000 / −1 → LO 0x80000000, HI 0.
- Backpressure: hold `out_ready` = 0 for 5 cycles after an SLL (x=1, shamt=31) → `res` holds 0x80000000 and `in_ready` stays 0. Release → next op accepted in the same cycle.
- Reset pulse 10 cycles into a MULTU → no `out_valid`; MFLO afterwards → 0. Stream of 8 back-to-back AND/OR ops at `out_ready` = 1 → 8 results on consecutive cycles.
- WIDTH=16: SRA 0x8000 by y=0x0013 (uses y[3:0] = 3) → 0xF000. DIVU 0xFFFF / 3 → LO 0x5555 after 17 cycles.
